// File: rtl/countdown_pkg.sv
// Shared types, segment table and BCD helpers for the four-digit countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is off in every entry.
    localparam logic [7:0] SEG_CODE [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        if (d > 4'd9) return 8'hFF;
        return SEG_CODE[d];
    endfunction

    function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Saturates at 0000 so a stray call can never wrap to 9999.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = (v != 16'h0000);
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_if.sv
// Control and display bundle between the board top level and the countdown timer.
interface countdown_if;
    logic        run_stop;
    logic        clear;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] bcd;
    logic        done;
    logic [7:0]  seg;
    logic [3:0]  seg_com;

    modport master (
        output run_stop, clear, load, load_val,
        input  bcd, done, seg, seg_com
    );

    modport slave (
        input  run_stop, clear, load, load_val,
        output bcd, done, seg, seg_com
    );
endinterface

// File: rtl/countdown_fnd_scan.sv
// Multiplexed common-anode 7-segment driver: one digit per scan period, registered outputs.
module countdown_fnd_scan #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd,
    input  logic        dp_en,
    input  logic        blank,
    output logic [7:0]  seg,
    output logic [3:0]  seg_com
);
    import countdown_pkg::*;

    localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SC_W-1:0] scan_cnt;
    logic [1:0]      idx;
    logic [3:0]      digit;
    logic [7:0]      code;

    always_comb begin
        digit = bcd[{idx, 2'b00} +: 4];
        code  = seg_of(digit);
        if (dp_en && idx == 2'd1) code = code & 8'h7F;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= SC_W'(SCAN_DIV - 1);
            idx      <= 2'd0;
            seg      <= 8'hFF;
            seg_com  <= 4'b1111;
        end else begin
            if (scan_cnt == '0) begin
                scan_cnt <= SC_W'(SCAN_DIV - 1);
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt - SC_W'(1);
            end
            seg     <= blank ? 8'hFF : code;
            seg_com <= ~(4'b0001 << idx);
        end
    end

endmodule

// File: rtl/countdown_10000.sv
// Four-digit BCD countdown timer with internal tick enable, completion flag and blinking display.
//   state | meaning
//   IDLE  | stopped, bcd holds reload value; load accepted
//   RUN   | decrementing once per tick
//   PAUSE | stopped mid-count; prescaler keeps the partial tick
//   DONE  | reached 0000; display blinks until clear
module countdown_10000 #(
    parameter int          CLK_HZ  = 100_000_000,
    parameter int          TICK_HZ = 10,
    parameter int          SCAN_HZ = 1000,
    parameter logic [15:0] PRESET  = 16'h9999
) (
    input logic       clk,
    input logic       rst,
    countdown_if.slave bus
);
    import countdown_pkg::*;

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [2:0] BLINK_LAST = 3'd4;

    state_t          state, next_state;
    logic [15:0]     bcd_q, bcd_next;
    logic [15:0]     reload_q, reload_next;
    logic [15:0]     dec_val;
    logic            done_q;
    logic [PS_W-1:0] ps;
    logic            ps_clr;
    logic            advancing;
    logic            tick;
    logic [2:0]      blink_cnt;
    logic            blink_off;
    logic [7:0]      seg_w;
    logic [3:0]      seg_com_w;

    assign advancing = (state == RUN) || (state == DONE);
    assign tick      = advancing && (ps == PS_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bcd_q    <= PRESET;
            reload_q <= PRESET;
            done_q   <= 1'b0;
        end else begin
            state    <= next_state;
            bcd_q    <= bcd_next;
            reload_q <= reload_next;
            done_q   <= (next_state == DONE);
        end
    end

    always_comb begin
        next_state  = state;
        bcd_next    = bcd_q;
        reload_next = reload_q;
        ps_clr      = 1'b0;
        dec_val     = bcd_dec(bcd_q);
        if (bus.clear) begin
            next_state = IDLE;
            bcd_next   = reload_q;
            ps_clr     = 1'b1;
        end else if (bus.load && state == IDLE) begin
            reload_next = bcd_clamp(bus.load_val);
            bcd_next    = bcd_clamp(bus.load_val);
            ps_clr      = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.run_stop) next_state = (bcd_q == 16'h0000) ? DONE : RUN;
                end
                RUN: begin
                    if (bus.run_stop) next_state = PAUSE;
                    // Reaching zero wins over a simultaneous pause so the count never sits at 0000 outside DONE.
                    if (tick) begin
                        bcd_next = dec_val;
                        if (dec_val == 16'h0000) next_state = DONE;
                    end
                end
                PAUSE: begin
                    if (bus.run_stop) next_state = RUN;
                end
                DONE: begin
                    next_state = DONE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps <= '0;
        end else if (ps_clr) begin
            ps <= '0;
        end else if (advancing) begin
            ps <= tick ? '0 : ps + PS_W'(1);
        end
    end

    // Five ticks per half-period of the completion blink; lit half first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= BLINK_LAST;
            blink_off <= 1'b0;
        end else if (next_state == DONE && state != DONE) begin
            blink_cnt <= BLINK_LAST;
            blink_off <= 1'b0;
        end else if (state == DONE && tick) begin
            if (blink_cnt == 3'd0) begin
                blink_cnt <= BLINK_LAST;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt - 3'd1;
            end
        end
    end

    countdown_fnd_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .bcd     (bcd_q),
        .dp_en   (1'b1),
        .blank   ((state == DONE) && blink_off),
        .seg     (seg_w),
        .seg_com (seg_com_w)
    );

    assign bus.bcd     = bcd_q;
    assign bus.done    = done_q;
    assign bus.seg     = seg_w;
    assign bus.seg_com = seg_com_w;

endmodule

// File: tb/tb_countdown_10000.sv
// Bench for countdown_10000: directed tables and sequences plus randomized traffic against a decimal reference model.
module tb_countdown_10000;

    localparam int CLK_HZ   = 100;
    localparam int TICK_HZ  = 10;
    localparam int SCAN_HZ  = 50;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    countdown_if bus ();

    countdown_10000 #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .SCAN_HZ (SCAN_HZ),
        .PRESET  (16'h9999)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (decimal count, spec rules) ----------------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mmode_t;

    localparam logic [7:0] SEGS [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };
    localparam int P10 [4] = '{1, 10, 100, 1000};

    mmode_t     m_mode;
    int         m_count, m_reload, m_ps, m_dticks, m_edges;
    logic [7:0] m_seg;
    logic [3:0] m_com;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int clamp_val(input logic [15:0] v);
        int r = 0;
        int w = 1;
        int d;
        logic [15:0] t = v;
        for (int i = 0; i < 4; i++) begin
            d = int'(t[3:0]);
            if (d > 9) d = 9;
            r = r + d * w;
            w = w * 10;
            t = t >> 4;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic rs, cl, ld, tk;
        logic [15:0] lv;
        int idx, dig;
        rs = bus.run_stop;
        cl = bus.clear;
        ld = bus.load;
        lv = bus.load_val;
        if (!rst) begin
            m_mode = M_IDLE; m_count = 9999; m_reload = 9999;
            m_ps = 0; m_dticks = 0; m_edges = 0;
            m_seg = 8'hFF; m_com = 4'hF;
        end else begin
            m_edges++;
            idx = ((m_edges - 1) / SCAN_DIV) % 4;
            dig = (m_count / P10[idx]) % 10;
            if (m_mode == M_DONE && ((m_dticks / 5) % 2) == 1) begin
                m_seg = 8'hFF;
            end else begin
                m_seg = SEGS[dig];
                if (idx == 1) m_seg[7] = 1'b0;
            end
            m_com = 4'hF;
            m_com[idx] = 1'b0;
            tk = (m_mode == M_RUN || m_mode == M_DONE) && (m_ps == TICK_DIV - 1);
            if (cl || (ld && m_mode == M_IDLE)) m_ps = 0;
            else if (m_mode == M_RUN || m_mode == M_DONE) m_ps = (m_ps + 1) % TICK_DIV;
            if (cl) begin
                m_mode = M_IDLE; m_count = m_reload;
            end else if (ld && m_mode == M_IDLE) begin
                m_reload = clamp_val(lv); m_count = m_reload;
            end else begin
                case (m_mode)
                    M_IDLE: if (rs) begin
                        if (m_count == 0) begin m_mode = M_DONE; m_dticks = 0; end
                        else m_mode = M_RUN;
                    end
                    M_RUN: begin
                        if (rs) m_mode = M_PAUSE;
                        if (tk) begin
                            m_count--;
                            if (m_count == 0) begin m_mode = M_DONE; m_dticks = 0; end
                        end
                    end
                    M_PAUSE: if (rs) m_mode = M_RUN;
                    M_DONE:  if (tk) m_dticks++;
                    default: ;
                endcase
            end
        end
        #1;
        check("model_bcd", bus.bcd, to_bcd(m_count));
        check("model_done", 16'(bus.done), 16'(m_mode == M_DONE));
        check("model_seg", 16'(bus.seg), 16'(m_seg));
        check("model_seg_com", 16'(bus.seg_com), 16'(m_com));
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic rs, input logic cl, input logic ld, input logic [15:0] v);
        bus.run_stop = rs;
        bus.clear    = cl;
        bus.load     = ld;
        bus.load_val = v;
        @(negedge clk);
        bus.run_stop = 1'b0;
        bus.clear    = 1'b0;
        bus.load     = 1'b0;
    endtask

    typedef struct {
        logic [15:0] lv;
        logic [15:0] exp_bcd;
    } load_vec_t;

    typedef struct {
        logic [3:0] com;
        logic [7:0] seg;
    } scan_vec_t;

    initial begin
        load_vec_t lvec [6];
        scan_vec_t svec [8];
        logic [3:0] prev_com;
        bit found;

        lvec[0] = '{16'h0A5F, 16'h0959};
        lvec[1] = '{16'hFFFF, 16'h9999};
        lvec[2] = '{16'h1000, 16'h1000};
        lvec[3] = '{16'h0000, 16'h0000};
        lvec[4] = '{16'h9A0B, 16'h9909};
        lvec[5] = '{16'h4321, 16'h4321};

        svec[0] = '{4'b1110, 8'h99}; svec[1] = '{4'b1110, 8'h99};
        svec[2] = '{4'b1101, 8'h30}; svec[3] = '{4'b1101, 8'h30};
        svec[4] = '{4'b1011, 8'hA4}; svec[5] = '{4'b1011, 8'hA4};
        svec[6] = '{4'b0111, 8'hF9}; svec[7] = '{4'b0111, 8'hF9};

        bus.run_stop = 1'b0; bus.clear = 1'b0; bus.load = 1'b0; bus.load_val = 16'h0;

        // Reset
        wait_cyc(3);
        check("rst_seg", 16'(bus.seg), 16'h00FF);
        check("rst_seg_com", 16'(bus.seg_com), 16'h000F);
        check("rst_bcd", bus.bcd, 16'h9999);
        check("rst_done", 16'(bus.done), 16'h0);
        rst = 1'b1;
        wait_cyc(1);
        check("first_digit", 16'(bus.seg_com), 16'b1110);
        wait_cyc(99);
        check("idle_hold", bus.bcd, 16'h9999);

        // Load clamp table
        foreach (lvec[i]) begin
            pulse(0, 1, 0, 16'h0);
            pulse(0, 0, 1, lvec[i].lv);
            check("load_clamp", bus.bcd, lvec[i].exp_bcd);
            check("load_done", 16'(bus.done), 16'h0);
        end

        // Run to zero and blink
        pulse(0, 1, 0, 16'h0);
        pulse(0, 0, 1, 16'h0012);
        pulse(1, 0, 0, 16'h0);
        wait_cyc(9);   check("run_pre_tick", bus.bcd, 16'h0012);
        wait_cyc(1);   check("run_tick1", bus.bcd, 16'h0011);
        wait_cyc(10);  check("run_tick2", bus.bcd, 16'h0010);
        wait_cyc(99);  check("run_last1", bus.bcd, 16'h0001);
        check("run_last1_done", 16'(bus.done), 16'h0);
        wait_cyc(1);   check("run_zero", bus.bcd, 16'h0000);
        check("run_zero_done", 16'(bus.done), 16'h1);
        wait_cyc(30);  check("blink_lit1", 16'(bus.seg == 8'hFF), 16'h0);
        wait_cyc(30);  check("blink_off1", 16'(bus.seg), 16'h00FF);
        wait_cyc(50);  check("blink_lit2", 16'(bus.seg == 8'hFF), 16'h0);
        wait_cyc(50);  check("blink_off2", 16'(bus.seg), 16'h00FF);
        check("zero_hold", bus.bcd, 16'h0000);

        // Pause keeps partial tick
        pulse(0, 1, 0, 16'h0);
        pulse(0, 0, 1, 16'h0012);
        pulse(1, 0, 0, 16'h0);
        wait_cyc(24);
        pulse(1, 0, 0, 16'h0);
        check("pause_val", bus.bcd, 16'h0010);
        wait_cyc(100); check("pause_hold", bus.bcd, 16'h0010);
        pulse(1, 0, 0, 16'h0);
        wait_cyc(4);   check("resume_pre", bus.bcd, 16'h0010);
        wait_cyc(1);   check("resume_tick", bus.bcd, 16'h0009);

        // Borrow, load ignored in RUN
        pulse(0, 1, 0, 16'h0);
        pulse(0, 0, 1, 16'h1000);
        pulse(1, 0, 0, 16'h0);
        wait_cyc(10);  check("borrow", bus.bcd, 16'h0999);
        pulse(0, 0, 1, 16'h0123);
        check("load_in_run", bus.bcd, 16'h0999);
        pulse(0, 1, 0, 16'h0);
        check("clear_reload", bus.bcd, 16'h1000);

        // Clear beats run_stop; run_stop at 0000 goes straight to DONE
        pulse(0, 0, 1, 16'h0050);
        pulse(1, 0, 0, 16'h0);
        wait_cyc(23);
        pulse(1, 1, 0, 16'h0);
        check("clr_prio_bcd", bus.bcd, 16'h0050);
        check("clr_prio_done", 16'(bus.done), 16'h0);
        wait_cyc(30);  check("clr_prio_idle", bus.bcd, 16'h0050);
        pulse(1, 0, 0, 16'h0);
        wait_cyc(10);  check("clr_prio_rerun", bus.bcd, 16'h0049);
        pulse(0, 1, 0, 16'h0);
        pulse(0, 0, 1, 16'h0000);
        pulse(1, 0, 0, 16'h0);
        check("zero_start_done", 16'(bus.done), 16'h1);
        pulse(0, 0, 1, 16'h0005);
        check("done_ignores_load", bus.bcd, 16'h0000);
        pulse(1, 0, 0, 16'h0);
        check("done_ignores_rs", 16'(bus.done), 16'h1);
        pulse(0, 1, 0, 16'h0);
        check("done_clear", 16'(bus.done), 16'h0);

        // Display scan of 1234
        pulse(0, 0, 1, 16'h1234);
        wait_cyc(2);
        found = 1'b0;
        prev_com = bus.seg_com;
        for (int i = 0; i < 16 && !found; i++) begin
            wait_cyc(1);
            if (prev_com == 4'b0111 && bus.seg_com == 4'b1110) found = 1'b1;
            else prev_com = bus.seg_com;
        end
        check("scan_sync", 16'(found), 16'h1);
        foreach (svec[i]) begin
            check("scan_com", 16'(bus.seg_com), 16'(svec[i].com));
            check("scan_seg", 16'(bus.seg), 16'(svec[i].seg));
            wait_cyc(1);
        end

        // Reset mid-count discards the earlier load
        pulse(0, 1, 0, 16'h0);
        pulse(0, 0, 1, 16'h0042);
        pulse(1, 0, 0, 16'h0);
        wait_cyc(15);
        rst = 1'b0;
        wait_cyc(2);
        check("mid_rst_bcd", bus.bcd, 16'h9999);
        check("mid_rst_seg", 16'(bus.seg), 16'h00FF);
        check("mid_rst_com", 16'(bus.seg_com), 16'h000F);
        rst = 1'b1;
        wait_cyc(1);
        pulse(0, 1, 0, 16'h0);
        check("mid_rst_reload", bus.bcd, 16'h9999);

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = int'($urandom_range(0, 999));
            bus.run_stop = (r < 50);
            bus.load     = (r >= 950 && r < 990);
            bus.clear    = (r >= 990);
            if ($urandom_range(0, 3) == 0) bus.load_val = 16'($urandom);
            else bus.load_val = 16'($urandom_range(0, 40));
            @(negedge clk);
        end
        bus.run_stop = 1'b0; bus.load = 1'b0; bus.clear = 1'b0;
        wait_cyc(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
